// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM state encoding, default divider width and the
// quotient value reported for a divide by zero.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } div_state_e;

  localparam int unsigned DIV_WIDTH = 4;

  // Sliced down to the divider width at the point of use (widths up to 16 are supported).
  localparam logic [15:0] DIV0_QUOTIENT = 16'hFFFF;

endpackage

// File: rtl/addsub_n.sv
// Ripple-carry adder/subtractor.
// Ports:
//   a, b      in  N  operands
//   mode      in  1  0 = a + b, 1 = a - b (b inverted, carry-in set)
//   sum       out N  result
//   carry     out 1  carry out of the MSB (no-borrow flag in subtract mode)
//   overflow  out 1  signed overflow
module addsub_n #(
  parameter int unsigned N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         mode,
  output logic [N-1:0] sum,
  output logic         carry,
  output logic         overflow
);

  logic [N-1:0] b_eff;
  logic [N:0]   c;

  always_comb begin
    b_eff = b ^ {N{mode}};
    c     = '0;
    c[0]  = mode;
    sum   = '0;
    for (int i = 0; i < N; i++) begin
      sum[i]   = a[i] ^ b_eff[i] ^ c[i];
      c[i+1]   = (a[i] & b_eff[i]) | (c[i] & (a[i] ^ b_eff[i]));
    end
    carry    = c[N];
    overflow = c[N] ^ c[N-1];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring unsigned divider, one quotient bit per clock.
// Ports:
//   clk          in  1      rising-edge clock
//   rst_n        in  1      asynchronous active-low reset
//   start        in  1      request; accepted only in IDLE
//   dividend     in  WIDTH  numerator, captured on accepted start
//   divisor      in  WIDTH  denominator, captured on accepted start
//   busy         out 1      iterations in progress
//   done         out 1      one-cycle pulse when results update
//   quotient     out WIDTH  result, held until the next completion
//   remainder    out WIDTH  result, held until the next completion
//   div_by_zero  out 1      last operation had a zero divisor
module seq_divider
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  div_state_e       state_q;
  logic [CntW-1:0]  cnt_q;
  // The partial remainder is always below the divisor once an iteration completes, so its
  // top (WIDTH+1'th) bit is provably zero and is not stored.
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] dvsr_q;

  logic [WIDTH:0]   rs;
  logic [WIDTH:0]   dvsr_ext;
  logic [WIDTH:0]   trial;
  logic             unused_carry;
  logic             unused_overflow;

  always_comb begin
    rs       = {r_q, q_q[WIDTH-1]};
    dvsr_ext = {1'b0, dvsr_q};
  end

  addsub_n #(
    .N(WIDTH + 1)
  ) u_trial_sub (
    .a        (rs),
    .b        (dvsr_ext),
    .mode     (1'b1),
    .sum      (trial),
    .carry    (unused_carry),
    .overflow (unused_overflow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      r_q         <= '0;
      q_q         <= '0;
      dvsr_q      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            dvsr_q <= divisor;
            q_q    <= dividend;
            r_q    <= '0;
            cnt_q  <= CntW'(WIDTH);
            if (divisor != '0) begin
              state_q <= RUN;
              busy    <= 1'b1;
            end else begin
              state_q <= FIN;
            end
          end
        end
        RUN: begin
          // Sign bit of the trial difference clear means the divisor fits.
          if (!trial[WIDTH]) begin
            r_q <= trial[WIDTH-1:0];
            q_q <= {q_q[WIDTH-2:0], 1'b1};
          end else begin
            r_q <= rs[WIDTH-1:0];
            q_q <= {q_q[WIDTH-2:0], 1'b0};
          end
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_q <= FIN;
            busy    <= 1'b0;
          end
        end
        FIN: begin
          done    <= 1'b1;
          state_q <= IDLE;
          if (dvsr_q == '0) begin
            quotient    <= DIV0_QUOTIENT[WIDTH-1:0];
            remainder   <= q_q;  // untouched dividend
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= q_q;
            remainder   <= r_q;
            div_by_zero <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=4) against an arithmetic reference model.
module tb_seq_divider;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_cmp = 0;
  int n_err = 0;

  seq_divider #(
    .WIDTH(W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer division, with the zero-divisor convention.
  function automatic void ref_div(input int a, input int b, output logic [W-1:0] q,
                                  output logic [W-1:0] r, output logic z);
    if (b == 0) begin
      q = '1;
      r = W'(a);
      z = 1'b1;
    end else begin
      q = W'(a / b);
      r = W'(a % b);
      z = 1'b0;
    end
  endfunction

  function automatic int ref_latency(input int b);
    return (b == 0) ? 1 : W + 1;
  endfunction

  function automatic int ref_busy_cycles(input int b);
    return (b == 0) ? 0 : W;
  endfunction

  // One operation: start at edge 0, scramble operands afterwards, report the edge index
  // after which done was first seen and how many sampled cycles busy was high.
  task automatic do_op(input int a, input int b, output int lat, output int bcnt);
    @(negedge clk);
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    @(posedge clk);
    lat  = -1;
    bcnt = 0;
    @(negedge clk);
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    if (busy) bcnt++;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {busy, done, quotient, remainder, div_by_zero});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat, bcnt;
    do_op(13, 3, lat, bcnt);
    n_cmp++;
    if (lat !== 5) begin
      n_err++;
      $display("FAIL basic_latency: got %0d expected 5", lat);
    end
    n_cmp++;
    if (bcnt !== 4) begin
      n_err++;
      $display("FAIL basic_busy_cycles: got %0d expected 4", bcnt);
    end
    n_cmp++;
    if ({quotient, remainder, div_by_zero} !== {4'd4, 4'd1, 1'b0}) begin
      n_err++;
      $display("FAIL basic_result: got q=%0d r=%0d z=%0d expected q=4 r=1 z=0",
               quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || quotient !== 4'd4 || remainder !== 4'd1) begin
      n_err++;
      $display("FAIL basic_done_pulse_hold: got done=%b q=%0d r=%0d expected done=0 q=4 r=1",
               done, quotient, remainder);
    end
  endtask

  // Directed table from the plan followed by random operand pairs.
  task automatic test_ops;
    int ta[3] = '{15, 2, 0};
    int tb[3] = '{1, 5, 7};
    int a, b, lat, bcnt;
    logic [W-1:0] eq, er;
    logic ez;
    for (int i = 0; i < 23; i++) begin
      if (i < 3) begin
        a = ta[i];
        b = tb[i];
      end else begin
        a = int'($urandom_range(15, 0));
        b = int'($urandom_range(15, 0));
      end
      ref_div(a, b, eq, er, ez);
      do_op(a, b, lat, bcnt);
      n_cmp++;
      if (lat !== ref_latency(b) || bcnt !== ref_busy_cycles(b)) begin
        n_err++;
        $display("FAIL op_timing %0d/%0d: got lat=%0d busy=%0d expected lat=%0d busy=%0d",
                 a, b, lat, bcnt, ref_latency(b), ref_busy_cycles(b));
      end
      n_cmp++;
      if ({quotient, remainder, div_by_zero} !== {eq, er, ez}) begin
        n_err++;
        $display("FAIL op_result %0d/%0d: got q=%0d r=%0d z=%0d expected q=%0d r=%0d z=%0d",
                 a, b, quotient, remainder, div_by_zero, eq, er, ez);
      end
    end
  endtask

  task automatic test_div_zero;
    int lat, bcnt;
    do_op(9, 0, lat, bcnt);
    n_cmp++;
    if (lat !== 1 || bcnt !== 0) begin
      n_err++;
      $display("FAIL div0_timing: got lat=%0d busy=%0d expected lat=1 busy=0", lat, bcnt);
    end
    n_cmp++;
    if ({quotient, remainder, div_by_zero} !== {4'd15, 4'd9, 1'b1}) begin
      n_err++;
      $display("FAIL div0_result: got q=%0d r=%0d z=%0d expected q=15 r=9 z=1",
               quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_busy_ignore;
    int ndone = 0;
    int first = -1;
    @(negedge clk);
    dividend = 4'd12;
    divisor  = 4'd4;
    start    = 1'b1;
    @(posedge clk);  // edge 0
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);  // edge 1
    @(negedge clk);
    dividend = 4'd15;
    divisor  = 4'd2;
    start    = 1'b1;
    @(posedge clk);  // edge 2
    @(negedge clk);
    start = 1'b0;
    for (int k = 3; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        ndone++;
        if (first < 0) first = k;
      end
    end
    n_cmp++;
    if (ndone !== 1 || first !== 5) begin
      n_err++;
      $display("FAIL busy_ignore_done: got %0d pulses first at %0d expected 1 at 5", ndone,
               first);
    end
    n_cmp++;
    if ({quotient, remainder, div_by_zero} !== {4'd3, 4'd0, 1'b0}) begin
      n_err++;
      $display("FAIL busy_ignore_result: got q=%0d r=%0d z=%0d expected q=3 r=0 z=0",
               quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_async_reset;
    int ndone = 0;
    int lat, bcnt;
    @(negedge clk);
    dividend = 4'd14;
    divisor  = 4'd3;
    start    = 1'b1;
    @(posedge clk);  // edge 0
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);  // edge 2
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      n_err++;
      $display("FAIL async_reset_outputs: got %b expected all zero",
               {busy, done, quotient, remainder, div_by_zero});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    n_cmp++;
    if (ndone !== 0) begin
      n_err++;
      $display("FAIL async_reset_no_done: got %0d pulses expected 0", ndone);
    end
    do_op(14, 3, lat, bcnt);
    n_cmp++;
    if (lat !== 5 || {quotient, remainder, div_by_zero} !== {4'd4, 4'd2, 1'b0}) begin
      n_err++;
      $display("FAIL async_reset_rerun: got lat=%0d q=%0d r=%0d z=%0d expected 5 4 2 0", lat,
               quotient, remainder, div_by_zero);
    end
  endtask

  // All pairs with start held high; the next pair is presented once the previous done is seen.
  task automatic test_back_to_back;
    int idx = 0;
    int edge_n = 0;
    int last_edge = 0;
    int a, b;
    logic [W-1:0] eq, er;
    logic ez;
    @(negedge clk);
    a = 0;
    b = 0;
    dividend = '0;
    divisor  = '0;
    start    = 1'b1;
    while (idx < 256 && edge_n < 256 * 6 + 40) begin
      @(posedge clk);
      edge_n++;
      @(negedge clk);
      if (done) begin
        ref_div(a, b, eq, er, ez);
        n_cmp++;
        if ({quotient, remainder, div_by_zero} !== {eq, er, ez}) begin
          n_err++;
          $display("FAIL sweep_result %0d/%0d: got q=%0d r=%0d z=%0d expected q=%0d r=%0d z=%0d",
                   a, b, quotient, remainder, div_by_zero, eq, er, ez);
        end
        n_cmp++;
        if (edge_n - last_edge !== 1 + ref_latency(b)) begin
          n_err++;
          $display("FAIL sweep_spacing %0d/%0d: got %0d cycles expected %0d", a, b,
                   edge_n - last_edge, 1 + ref_latency(b));
        end
        last_edge = edge_n;
        idx++;
        if (idx < 256) begin
          a = idx >> 4;
          b = idx & 15;
          dividend = W'(a);
          divisor  = W'(b);
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    if (idx < 256) begin
      n_cmp++;
      n_err++;
      $display("FAIL sweep_timeout: got %0d results expected 256", idx);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ops();
    test_div_zero();
    test_busy_ignore();
    test_async_reset();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
